// File: rtl/coin_pulse_scheduler.sv
// Coin-edge capture, per-denomination queueing and round-robin pulse issue.
// Optional post-dispense lockout: define COIN_DISPENSE_HOLD_EN.
module coin_pulse_scheduler #(
    parameter int PEND_MAX    = 3,
    parameter int GAP         = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin1_in,
    input  logic       coin2_in,
    input  logic       coin5_in,
    input  logic       dispense,
    output logic       one_rupee,
    output logic       two_rupees,
    output logic       five_rupees,
    output logic       coin_reject,
    output logic [4:0] pending_total,
    output logic       busy
);

    localparam int CW = $clog2(PEND_MAX + 1);
    localparam logic [CW-1:0] PMAX   = CW'(PEND_MAX);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [3:0]    GAP_L  = 4'(GAP);
    localparam logic [3:0]    HOLD_L = 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    prev_q;
    logic [2:0]    coin_v;
    logic [2:0]    edge_w;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    nz;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    tmr_q, tmr_d;
    logic [2:0]    grant;
    logic [1:0]    gidx;
    logic [2:0]    issue;
    logic [2:0]    rej;
    logic          hold_req;
    logic          hold_disp;

    logic [2:0]    pulse_q;
    logic          reject_q;
    logic [4:0]    total_q, total_d;
    logic          busy_q, busy_d;

    assign coin_v = {coin5_in, coin2_in, coin1_in};
    assign edge_w = coin_v & ~prev_q;

`ifdef COIN_DISPENSE_HOLD_EN
    logic hold_q, hold_d;

    // Request latched from dispense; consumed on entry to HOLD
    always_comb begin
        hold_d = hold_q;
        if (dispense && state_q != S_HOLD) hold_d = 1'b1;
        if (state_d == S_HOLD) hold_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= 1'b0;
        else       hold_q <= hold_d;
    end

    assign hold_req  = hold_q;
    assign hold_disp = dispense;
`else
    logic unused_dispense;
    assign unused_dispense = dispense;
    assign hold_req        = 1'b0;
    assign hold_disp       = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) nz[i] = (cnt_q[i] != '0);
    end

    // Search starts just after the last granted denomination
    always_comb begin
        grant = 3'b000;
        unique case (ptr_q)
            2'd0: begin
                if (nz[1])      grant = 3'b010;
                else if (nz[2]) grant = 3'b100;
                else if (nz[0]) grant = 3'b001;
            end
            2'd1: begin
                if (nz[2])      grant = 3'b100;
                else if (nz[0]) grant = 3'b001;
                else if (nz[1]) grant = 3'b010;
            end
            default: begin
                if (nz[0])      grant = 3'b001;
                else if (nz[1]) grant = 3'b010;
                else if (nz[2]) grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        gidx = 2'd0;
        if (grant[1])      gidx = 2'd1;
        else if (grant[2]) gidx = 2'd2;
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        ptr_d   = ptr_q;
        issue   = 3'b000;
        unique case (state_q)
            S_IDLE: begin
                if (hold_req) begin
                    state_d = S_HOLD;
                    tmr_d   = HOLD_L;
                end else if (|grant) begin
                    state_d = S_ISSUE;
                    issue   = grant;
                    ptr_d   = gidx;
                end
            end
            S_ISSUE: begin
                if (hold_req) begin
                    state_d = S_HOLD;
                    tmr_d   = HOLD_L;
                end else begin
                    state_d = S_GAP;
                    tmr_d   = GAP_L;
                end
            end
            S_GAP: begin
                if (hold_req) begin
                    state_d = S_HOLD;
                    tmr_d   = HOLD_L;
                end else if (tmr_q <= 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (hold_disp) begin
                    tmr_d = HOLD_L;
                end else if (tmr_q <= 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
        endcase
    end

    // Edge and issue together cancel; an edge on a full counter is rejected
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            rej[i]   = 1'b0;
            if (edge_w[i] && !issue[i]) begin
                if (cnt_q[i] == PMAX) rej[i] = 1'b1;
                else                  cnt_d[i] = cnt_q[i] + C_ONE;
            end else if (!edge_w[i] && issue[i]) begin
                cnt_d[i] = cnt_q[i] - C_ONE;
            end
        end
    end

    always_comb begin
        total_d = 5'(cnt_d[0]) + 5'(cnt_d[1]) + 5'(cnt_d[2]);
        busy_d  = (state_d != S_IDLE) || (total_d != 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prev_q   <= 3'b111;
            ptr_q    <= 2'd2;
            tmr_q    <= 4'd0;
            pulse_q  <= 3'b000;
            reject_q <= 1'b0;
            total_q  <= 5'd0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= coin_v;
            ptr_q    <= ptr_d;
            tmr_q    <= tmr_d;
            pulse_q  <= issue;
            reject_q <= |rej;
            total_q  <= total_d;
            busy_q   <= busy_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign one_rupee     = pulse_q[0];
    assign two_rupees    = pulse_q[1];
    assign five_rupees   = pulse_q[2];
    assign coin_reject   = reject_q;
    assign pending_total = total_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_coin_pulse_scheduler.sv
// Bench for coin_pulse_scheduler: directed scenarios plus random coin
// traffic checked against a count/timestamp reference model.
module tb_coin_pulse_scheduler;

    localparam int PEND_MAX = 3;
    localparam int GAP      = 2;
    localparam int HOLD_CYC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       c1, c2, c5, disp;
    logic       one_rupee, two_rupees, five_rupees, coin_reject;
    logic [4:0] pending_total;
    logic       busy;

    coin_pulse_scheduler #(
        .PEND_MAX(PEND_MAX),
        .GAP(GAP),
        .HOLD_CYCLES(HOLD_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .coin1_in(c1),
        .coin2_in(c2),
        .coin5_in(c5),
        .dispense(disp),
        .one_rupee(one_rupee),
        .two_rupees(two_rupees),
        .five_rupees(five_rupees),
        .coin_reject(coin_reject),
        .pending_total(pending_total),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending counts, previous levels, and the earliest
    // clock edge at which the next grant may happen.
    int pend[3];
    bit prv[3];
    int last_g;
    int next_ok;
    int cyc = 0;
    bit e_pulse[3];
    bit e_rej;
    int e_total;
    bit e_busy;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pend[i]    = 0;
            prv[i]     = 1'b1;
            e_pulse[i] = 1'b0;
        end
        last_g  = 2;
        next_ok = cyc;
        e_rej   = 1'b0;
        e_total = 0;
        e_busy  = 1'b0;
    endtask

    task automatic model_edge(input bit a, input bit b, input bit f);
        bit in[3];
        bit e[3];
        int g;
        int t;
        in[0] = a; in[1] = b; in[2] = f;
        t = cyc;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            e[i]   = in[i] && !prv[i];
            prv[i] = in[i];
        end
        g = -1;
        if (t >= next_ok) begin
            for (int k = 1; k <= 3; k++) begin
                int j;
                j = (last_g + k) % 3;
                if (g < 0 && pend[j] > 0) g = j;
            end
        end
        if (g >= 0) begin
            last_g  = g;
            next_ok = t + GAP + 2;
        end
        e_rej   = 1'b0;
        e_total = 0;
        for (int i = 0; i < 3; i++) begin
            e_pulse[i] = (i == g);
            if (e[i] && i != g && pend[i] == PEND_MAX) e_rej = 1'b1;
            else pend[i] = pend[i] + int'(e[i]) - int'(i == g);
            e_total += pend[i];
        end
        e_busy = (t < next_ok - 1) || (e_total > 0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".one"}, 32'(one_rupee), 32'(e_pulse[0]));
        chk({tag, ".two"}, 32'(two_rupees), 32'(e_pulse[1]));
        chk({tag, ".five"}, 32'(five_rupees), 32'(e_pulse[2]));
        chk({tag, ".reject"}, 32'(coin_reject), 32'(e_rej));
        chk({tag, ".total"}, 32'(pending_total), 32'(e_total));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".excl"},
            32'(int'(one_rupee) + int'(two_rupees) + int'(five_rupees) <= 1),
            32'd1);
    endtask

    // Drive at a falling edge, advance one full cycle, compare.
    task automatic step(input string tag, input bit a, input bit b,
                        input bit f, input bit d);
        c1 = a; c2 = b; c5 = f; disp = d;
        model_edge(a, b, f);
        @(negedge clk);
        check_all(tag);
    endtask

    int nrej;
    int j1, j2;

    initial begin
        reset = 1'b1;
        c1 = 0; c2 = 0; c5 = 0; disp = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        model_reset();

        // Single 2-rupee coin
        step("t1_idle", 0, 0, 0, 0);
        step("t1_edge", 0, 1, 0, 0);
        chk("t1_pend1", 32'(pending_total), 32'd1);
        step("t1_issue", 0, 0, 0, 0);
        chk("t1_pulse", 32'(two_rupees), 32'd1);
        chk("t1_pend0", 32'(pending_total), 32'd0);
        for (int i = 0; i < 6; i++) step("t1_drain", 0, 0, 0, 0);
        chk("t1_idlebusy", 32'(busy), 32'd0);

        // Three slots at once
        step("t2_edge", 1, 1, 1, 0);
        chk("t2_pend3", 32'(pending_total), 32'd3);
        for (int i = 0; i < 14; i++) step("t2_drain", 0, 0, 0, 0);

        // Rapid 5-rupee edges overflow the queue once
        nrej = 0;
        for (int i = 0; i < 8; i++) begin
            step("t3_hi", 0, 0, 1, 0);
            nrej += int'(coin_reject);
            step("t3_lo", 0, 0, 0, 0);
            nrej += int'(coin_reject);
        end
        chk("t3_rejects", 32'(nrej), 32'd1);
        for (int i = 0; i < 16; i++) step("t3_drain", 0, 0, 0, 0);

        // 1-rupee edge coincident with a 1-rupee issue
        step("t4_c2", 0, 1, 0, 0);
        step("t4_iss2", 0, 0, 0, 0);
        step("t4_c1", 1, 0, 0, 0);
        step("t4_w1", 0, 0, 0, 0);
        step("t4_w2", 0, 0, 0, 0);
        step("t4_both", 1, 0, 0, 0);
        chk("t4_pulse", 32'(one_rupee), 32'd1);
        chk("t4_keep", 32'(pending_total), 32'd1);
        for (int i = 0; i < 8; i++) step("t4_drain", 0, 0, 0, 0);

        // Reset during GAP with two coins pending
        step("t5_edge", 1, 1, 1, 0);
        step("t5_issue", 0, 0, 0, 0);
        step("t5_gap", 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        c1 = 1'b1;
        #1;
        chk("t5_rst_pulse", 32'({one_rupee, two_rupees, five_rupees}), 32'd0);
        chk("t5_rst_total", 32'(pending_total), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_rej", 32'(coin_reject), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step("t5_held", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("t5_after", 0, 0, 0, 0);

        // Random coin traffic
        for (int i = 0; i < 500; i++) begin
            bit a, b, f, d;
            a = ($urandom_range(0, 2) == 0) ? ~c1 : c1;
            b = ($urandom_range(0, 3) == 0) ? ~c2 : c2;
            f = ($urandom_range(0, 2) == 0) ? ~c5 : c5;
`ifdef COIN_DISPENSE_HOLD_EN
            d = 1'b0;
`else
            d = ($urandom_range(0, 4) == 0);
`endif
            step("rand", a, b, f, d);
        end
        for (int i = 0; i < 40; i++) step("rand_drain", 0, 0, 0, 0);

        // Dispense arriving together with two coins
        reset = 1'b1;
        c1 = 0; c2 = 0; c5 = 0; disp = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        c1 = 1; c2 = 1; disp = 1;
        @(negedge clk);
        chk("t6_pend2", 32'(pending_total), 32'd2);
        c1 = 0; c2 = 0; disp = 0;
`ifdef COIN_DISPENSE_HOLD_EN
        j1 = 2 + HOLD_CYC;
`else
        j1 = 1;
`endif
        j2 = j1 + GAP + 2;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk($sformatf("t6_one_%0d", j), 32'(one_rupee), 32'(j == j1));
            chk($sformatf("t6_two_%0d", j), 32'(two_rupees), 32'(j == j2));
        end
        chk("t6_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
